alu_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that lets NREQ requesters (core datapath, address unit, debug port, ...) share one combinational logic/arithmetic unit (Op_And/Op_Or/Op_Xor/adder bank) in the MicroUAZ core.
- Selects one requester, registers its operands and opcode onto the shared unit's inputs, captures the result one cycle later, and returns it with a one-cycle done pulse to the winner.

---
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter and sequencer that shares one
//               combinational logic/arithmetic unit among NREQ requesters.
//               The winner's operands and opcode are registered onto the
//               shared unit. The result is captured one cycle later and
//               returned to the winner with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int OPW  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] op_bus,
    input  logic [NREQ*N-1:0]   a_bus,
    input  logic [NREQ*N-1:0]   b_bus,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [OPW-1:0]      alu_op,
    input  logic [N-1:0]        alu_y,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [N-1:0]        result,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;

    // Round-robin scan: first requester at or after ptr, wrapping at NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: grant/operand capture, result capture, done pulse, pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        win    <= pick_idx;
                        gnt    <= ONE_HOT0 << pick_idx;
                        alu_a  <= a_bus[pick_idx*N +: N];
                        alu_b  <= b_bus[pick_idx*N +: N];
                        alu_op <= op_bus[pick_idx*OPW +: OPW];
                    end
                end
                EXEC: begin
                    result <= alu_y;
                    done   <= ONE_HOT0 << win;
                end
                RESP: begin
                    done <= '0;
                    gnt  <= '0;
                    // The winner drops to lowest priority for the next scan.
                    if (win == IW'(NREQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= win + 1'b1;
                    end
                end
                default: begin
                    done <= '0;
                    gnt  <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with an
//               external OR unit on the shared ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int OPW  = 3;
    localparam logic [OPW-1:0] OP_OR = 3'b001;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*OPW-1:0] op_bus;
    logic [NREQ*N-1:0]   a_bus;
    logic [NREQ*N-1:0]   b_bus;
    logic [N-1:0]        alu_a;
    logic [N-1:0]        alu_b;
    logic [OPW-1:0]      alu_op;
    logic [N-1:0]        alu_y;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [N-1:0]        result;
    logic                busy;

    int checks;
    int failures;

    alu_share_arbiter #(.N(N), .NREQ(NREQ), .OPW(OPW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op_bus (op_bus),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_y  (alu_y),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    // External shared unit: OR for the OR opcode, AND otherwise.
    assign alu_y = (alu_op == OP_OR) ? (alu_a | alu_b) : (alu_a & alu_b);

    // Clock generator.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Advance to one time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [OPW-1:0] op);
        a_bus[i*N +: N]       = a;
        b_bus[i*N +: N]       = b;
        op_bus[i*OPW +: OPW]  = op;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Reset holds everything at zero even with all requests high; first grant is 0.
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        a_bus = '0; b_bus = '0; op_bus = '0;
        tick(); tick();
        checks++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt_done: got gnt=%b done=%b want 0000/0000", gnt, done);
        end
        checks++;
        if (result !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_result_busy: got result=%h busy=%b want 00/0", result, busy);
        end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000) begin
            failures++;
            $display("FAIL reset_alu_regs: got a=%h b=%h op=%b want 00/00/000", alu_a, alu_b, alu_op);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: got gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        req = '0;
        tick(); tick();
    endtask

    // One OR request from requester 2.
    task automatic test_single_or();
        apply_reset();
        set_slot(2, 8'hA0, 8'h0C, OP_OR);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || done !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b done=%b busy=%b want 0100/0000/1", gnt, done, busy);
        end
        checks++;
        if (alu_a !== 8'hA0 || alu_b !== 8'h0C || alu_op !== OP_OR) begin
            failures++;
            $display("FAIL single_operands: got a=%h b=%h op=%b want a0/0c/001", alu_a, alu_b, alu_op);
        end
        tick();
        checks++;
        if (done !== 4'b0100 || result !== 8'hAC || gnt !== 4'b0100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_done: got done=%b result=%h gnt=%b busy=%b want 0100/ac/0100/1",
                     done, result, gnt, busy);
        end
        req = '0;
        tick();
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0 || result !== 8'hAC) begin
            failures++;
            $display("FAIL single_idle: got done=%b gnt=%b busy=%b result=%h want 0000/0000/0/ac",
                     done, gnt, busy, result);
        end
    endtask

    // Three requesters held high: strict rotation 0,1,3 with pointer wrap.
    task automatic test_contention();
        logic [NREQ-1:0] exp_onehot [6];
        logic [N-1:0]    exp_res    [6];
        exp_onehot = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        exp_res    = '{8'h33, 8'h44, 8'h88, 8'h33, 8'h44, 8'h88};
        apply_reset();
        set_slot(0, 8'h11, 8'h22, OP_OR);
        set_slot(1, 8'h40, 8'h04, OP_OR);
        set_slot(2, 8'hFF, 8'hFF, OP_OR);
        set_slot(3, 8'h80, 8'h08, OP_OR);
        req = 4'b1011;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if (gnt !== exp_onehot[t]) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: got %b want %b", t, gnt, exp_onehot[t]);
            end
            tick();
            checks++;
            if (done !== exp_onehot[t] || result !== exp_res[t]) begin
                failures++;
                $display("FAIL contention_done[%0d]: got done=%b result=%h want %b/%h",
                         t, done, result, exp_onehot[t], exp_res[t]);
            end
            tick();
            checks++;
            if (done !== 4'b0000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL contention_idle[%0d]: got done=%b busy=%b want 0000/0", t, done, busy);
            end
        end
        req = '0;
    endtask

    // Operand change after the grant edge must not affect the result.
    task automatic test_operand_change();
        apply_reset();
        set_slot(1, 8'h01, 8'h02, OP_OR);
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL opchg_grant: got %b want 0010", gnt);
        end
        set_slot(1, 8'hFF, 8'h02, 3'b000);
        tick();
        checks++;
        if (done !== 4'b0010 || result !== 8'h03 || alu_a !== 8'h01 || alu_op !== OP_OR) begin
            failures++;
            $display("FAIL opchg_result: got done=%b result=%h a=%h op=%b want 0010/03/01/001",
                     done, result, alu_a, alu_op);
        end
        req = '0;
        tick();
    endtask

    // Requester 0 withdraws during EXEC: its done still pulses, no re-grant.
    task automatic test_withdraw();
        apply_reset();
        set_slot(0, 8'h0F, 8'hF0, OP_OR);
        set_slot(1, 8'h05, 8'h50, OP_OR);
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL withdraw_grant: got %b want 0001", gnt);
        end
        req = 4'b0010;
        tick();
        checks++;
        if (done !== 4'b0001 || result !== 8'hFF) begin
            failures++;
            $display("FAIL withdraw_done: got done=%b result=%h want 0001/ff", done, result);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL withdraw_next_grant: got %b want 0010", gnt);
        end
        tick();
        checks++;
        if (done !== 4'b0010 || result !== 8'h55) begin
            failures++;
            $display("FAIL withdraw_done1: got done=%b result=%h want 0010/55", done, result);
        end
        req = '0;
        tick(); tick(); tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_no_regrant: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    // Reset during EXEC drops the transaction and returns ptr to 0.
    task automatic test_reset_mid_op();
        apply_reset();
        set_slot(0, 8'h12, 8'h34, OP_OR);
        set_slot(1, 8'h21, 8'h42, OP_OR);
        set_slot(2, 8'h0A, 8'h05, OP_OR);
        set_slot(3, 8'h00, 8'h00, OP_OR);
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_grant: got gnt=%b busy=%b want 1000/1", gnt, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || alu_a !== 8'h00 || done !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_async: got gnt=%b busy=%b a=%h done=%b want 0000/0/00/0000",
                     gnt, busy, alu_a, done);
        end
        tick();
        checks++;
        if (done !== 4'b0000 || result !== 8'h00) begin
            failures++;
            $display("FAIL midrst_no_done: got done=%b result=%h want 0000/00", done, result);
        end
        rst_n = 1'b1;
        req   = 4'b0110;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_ptr: got gnt=%b want 0010", gnt);
        end
        tick();
        checks++;
        if (done !== 4'b0010 || result !== 8'h63) begin
            failures++;
            $display("FAIL midrst_done: got done=%b result=%h want 0010/63", done, result);
        end
        req = '0;
        tick();
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        a_bus    = '0;
        b_bus    = '0;
        op_bus   = '0;
        test_reset();
        test_single_or();
        test_contention();
        test_operand_change();
        test_withdraw();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
